// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode trap CSR file:
// CSR addresses, csr_op encodings, interrupt bits and causes, WFI states.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSI_BIT = 3;
    localparam int MTI_BIT = 7;
    localparam int MEI_BIT = 11;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } wfi_state_e;

    function automatic logic [31:0] csr_apply(
        input csr_op_e     op,
        input logic [31:0] old,
        input logic [31:0] wd
    );
        logic [31:0] v;
        v = old;
        unique case (op)
            OP_RW:   v = wd;
            OP_RS:   v = old | wd;
            OP_RC:   v = old & ~wd;
            default: v = old;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit free-running counter with independent lo/hi overwrite.
// Ports: i_inc increment enable, i_we_lo/i_we_hi half writes, o_value count.
module csr_counter64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);

    logic [63:0] r_cnt;
    logic [63:0] w_nxt;

    // A written half replaces the incremented value for that half only.
    always_comb begin
        w_nxt = r_cnt + 64'(i_inc);
        if (i_we_lo) w_nxt[31:0]  = i_wdata;
        if (i_we_hi) w_nxt[63:32] = i_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_cnt <= '0;
        else       r_cnt <= w_nxt;
    end

    assign o_value = r_cnt;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode trap CSR file: trap/mret state, CSR access, counters, WFI sleep.
// Ports: exception-controller handshake, CSR port, redirect, wfi_stall. Option: MTVEC_VECTORED_EN.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int          PC_WIDTH    = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                trapped,
    input  logic                mret,
    input  logic                wfi,
    input  logic                retired,
    input  logic [PC_WIDTH-1:0] ecp,
    input  logic [3:0]          ecause,
    input  logic                interupt,
    output logic                sip,
    output logic                tip,
    output logic                eip,
    input  logic                mtip_in,
    input  logic                meip_in,
    input  logic                csr_valid,
    input  logic [11:0]         csr_addr,
    input  logic [1:0]          csr_op,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    output logic                csr_illegal,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                wfi_stall
);

    logic                r_st_mie;
    logic                r_st_mpie;
    logic [31:0]         r_mie;
    logic                r_msip;
    logic [PC_WIDTH-1:0] r_mtvec;
    logic [PC_WIDTH-1:0] r_mepc;
    logic [31:0]         r_mcause;
    logic [31:0]         r_mscratch;
    logic                r_redir_v;
    logic [PC_WIDTH-1:0] r_redir_pc;
    wfi_state_e          r_state;
    wfi_state_e          w_state_nxt;

    logic [31:0]         w_mstatus;
    logic [31:0]         w_mip;
    logic [31:0]         w_pend;
    logic [31:0]         w_rdata;
    logic                w_hit;
    logic                w_wr_op;
    logic                w_we;
    logic [31:0]         w_wval;
    logic [PC_WIDTH-1:0] w_base;
    logic [PC_WIDTH-1:0] w_tgt;
    logic [63:0]         w_mcycle;
    logic [63:0]         w_minstret;

    // MPP is hardwired to machine mode.
    assign w_mstatus = 32'h0000_1800
                     | (32'(r_st_mpie) << 7)
                     | (32'(r_st_mie) << 3);

    assign w_mip = (32'(meip_in) << MEI_BIT)
                 | (32'(mtip_in) << MTI_BIT)
                 | (32'(r_msip) << MSI_BIT);

    assign w_pend = w_mip & r_mie;

    assign sip = r_st_mie & w_pend[MSI_BIT];
    assign tip = r_st_mie & w_pend[MTI_BIT];
    assign eip = r_st_mie & w_pend[MEI_BIT];

    always_comb begin
        w_rdata = '0;
        w_hit   = 1'b1;
        unique case (csr_addr)
            CSR_MSTATUS:   w_rdata = w_mstatus;
            CSR_MIE:       w_rdata = r_mie;
            CSR_MTVEC:     w_rdata = 32'(r_mtvec);
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = 32'(r_mepc);
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MIP:       w_rdata = w_mip;
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
            CSR_MHARTID:   w_rdata = HART_ID;
            default:       w_hit   = 1'b0;
        endcase
    end

    assign csr_rdata   = w_rdata;
    assign w_wr_op     = (csr_op != OP_READ);
    assign csr_illegal = ~w_hit | ((csr_addr == CSR_MHARTID) & w_wr_op);

    // Trap and mret own the CSR state in their cycle; a coincident write is lost.
    assign w_we   = csr_valid & w_wr_op & ~csr_illegal & ~trapped & ~mret;
    assign w_wval = csr_apply(csr_op_e'(csr_op), w_rdata, csr_wdata);

    assign w_base = {r_mtvec[PC_WIDTH-1:2], 2'b00};

`ifdef MTVEC_VECTORED_EN
    assign w_tgt = (interupt && r_mtvec[1:0] == 2'b01)
                 ? w_base + PC_WIDTH'({ecause, 2'b00})
                 : w_base;
`else
    assign w_tgt = w_base;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie      <= '0;
            r_msip     <= 1'b0;
            r_mtvec    <= PC_WIDTH'(MTVEC_RESET);
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mscratch <= '0;
            r_redir_v  <= 1'b0;
            r_redir_pc <= '0;
        end else begin
            r_redir_v <= 1'b0;
            if (trapped) begin
                r_mepc     <= ecp;
                r_mcause   <= {interupt, 27'b0, ecause};
                r_st_mpie  <= r_st_mie;
                r_st_mie   <= 1'b0;
                r_redir_v  <= 1'b1;
                r_redir_pc <= w_tgt;
            end else if (mret) begin
                r_st_mie   <= r_st_mpie;
                r_st_mpie  <= 1'b1;
                r_redir_v  <= 1'b1;
                r_redir_pc <= r_mepc;
            end else if (w_we) begin
                unique case (csr_addr)
                    CSR_MSTATUS: begin
                        r_st_mie  <= w_wval[3];
                        r_st_mpie <= w_wval[7];
                    end
                    CSR_MIE:      r_mie      <= w_wval & MIE_WMASK;
`ifdef MTVEC_VECTORED_EN
                    CSR_MTVEC:    r_mtvec    <= w_wval[PC_WIDTH-1:0];
`else
                    CSR_MTVEC:    r_mtvec    <= {w_wval[PC_WIDTH-1:2], 2'b00};
`endif
                    CSR_MSCRATCH: r_mscratch <= w_wval;
                    CSR_MEPC:     r_mepc     <= {w_wval[PC_WIDTH-1:2], 2'b00};
                    CSR_MCAUSE:   r_mcause   <= w_wval;
                    CSR_MIP:      r_msip     <= w_wval[MSI_BIT];
                    default: ;
                endcase
            end
        end
    end

    assign redirect_valid = r_redir_v;
    assign redirect_pc    = r_redir_pc;

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rstn    (rstn),
        .i_inc   (1'b1),
        .i_we_lo (w_we && csr_addr == CSR_MCYCLE),
        .i_we_hi (w_we && csr_addr == CSR_MCYCLEH),
        .i_wdata (w_wval),
        .o_value (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rstn    (rstn),
        .i_inc   (retired),
        .i_we_lo (w_we && csr_addr == CSR_MINSTRET),
        .i_we_hi (w_we && csr_addr == CSR_MINSTRETH),
        .i_wdata (w_wval),
        .o_value (w_minstret)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // Wake-up ignores mstatus.MIE so a masked interrupt still ends the sleep.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:   if (wfi && !trapped) w_state_nxt = ST_SLEEP;
            ST_SLEEP: if (trapped || w_pend != '0) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    assign wfi_stall = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios, then random traffic
// compared every cycle against a behavioural model of the CSR file.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        trapped, mret, wfi, retired;
    logic [31:0] ecp;
    logic [3:0]  ecause;
    logic        interupt;
    logic        sip, tip, eip;
    logic        mtip_in, meip_in;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wfi_stall;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_trap_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .trapped        (trapped),
        .mret           (mret),
        .wfi            (wfi),
        .retired        (retired),
        .ecp            (ecp),
        .ecause         (ecause),
        .interupt       (interupt),
        .sip            (sip),
        .tip            (tip),
        .eip            (eip),
        .mtip_in        (mtip_in),
        .meip_in        (meip_in),
        .csr_valid      (csr_valid),
        .csr_addr       (csr_addr),
        .csr_op         (csr_op),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wfi_stall      (wfi_stall)
    );

    // Behavioural model of the architectural state.
    bit              m_mie_g, m_mpie, m_msip, m_sleep, m_rv;
    bit [31:0]       m_mie, m_mtvec, m_mepc, m_mcause, m_mscratch, m_rpc;
    longint unsigned m_cyc, m_ins;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mie_g = 0; m_mpie = 0; m_msip = 0; m_sleep = 0; m_rv = 0;
        m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_mscratch = 0; m_rpc = 0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic bit [31:0] m_mip();
        return {20'b0, meip_in, 3'b0, mtip_in, 3'b0, m_msip, 3'b0};
    endfunction

    function automatic bit [32:0] mread(input bit [11:0] a);
        case (a)
            12'h300: return {1'b1, 32'h1800 + 32'(m_mpie) * 128 + 32'(m_mie_g) * 8};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h344: return {1'b1, m_mip()};
            12'hB00: return {1'b1, m_cyc[31:0]};
            12'hB80: return {1'b1, m_cyc[63:32]};
            12'hB02: return {1'b1, m_ins[31:0]};
            12'hB82: return {1'b1, m_ins[63:32]};
            12'hF14: return {1'b1, 32'd0};
            default: return 33'd0;
        endcase
    endfunction

    task automatic check_outs();
        bit [32:0] rd;
        bit [31:0] pend;
        bit        ill;
        #1;
        rd   = mread(csr_addr);
        ill  = !rd[32] || (csr_addr == 12'hF14 && csr_op != 2'b00);
        pend = m_mip() & m_mie;
        chk("illegal", csr_illegal, ill);
        chk("rdata", csr_rdata, rd[31:0]);
        chk("sip", sip, m_mie_g && pend[3]);
        chk("tip", tip, m_mie_g && pend[7]);
        chk("eip", eip, m_mie_g && pend[11]);
        chk("redir_v", redirect_valid, m_rv);
        if (m_rv) chk("redir_pc", redirect_pc, m_rpc);
        chk("stall", wfi_stall, m_sleep);
    endtask

    task automatic adv();
        bit [32:0] rd;
        bit [31:0] nv, pend;
        bit        ill, we;
        rd   = mread(csr_addr);
        ill  = !rd[32] || (csr_addr == 12'hF14 && csr_op != 2'b00);
        pend = m_mip() & m_mie;
        case (csr_op)
            2'b01:   nv = csr_wdata;
            2'b10:   nv = rd[31:0] | csr_wdata;
            2'b11:   nv = rd[31:0] & ~csr_wdata;
            default: nv = rd[31:0];
        endcase
        we = csr_valid && csr_op != 0 && !ill && !trapped && !mret;
        @(posedge clk);
        m_cyc++;
        if (retired) m_ins++;
        if (!m_sleep) m_sleep = wfi && !trapped;
        else if (trapped || pend != 0) m_sleep = 0;
        m_rv = 0;
        if (trapped) begin
            m_rv  = 1;
            m_rpc = m_mtvec & ~32'd3;
`ifdef MTVEC_VECTORED_EN
            if (interupt && m_mtvec[1:0] == 2'b01) m_rpc += 4 * ecause;
`endif
            m_mepc   = ecp;
            m_mcause = {interupt, 27'b0, ecause};
            m_mpie   = m_mie_g;
            m_mie_g  = 0;
        end else if (mret) begin
            m_rv    = 1;
            m_rpc   = m_mepc;
            m_mie_g = m_mpie;
            m_mpie  = 1;
        end else if (we) begin
            case (csr_addr)
                12'h300: begin m_mie_g = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie = nv & 32'h888;
`ifdef MTVEC_VECTORED_EN
                12'h305: m_mtvec = nv;
`else
                12'h305: m_mtvec = nv & ~32'd3;
`endif
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'h344: m_msip = nv[3];
                12'hB00: m_cyc[31:0] = nv;
                12'hB80: m_cyc[63:32] = nv;
                12'hB02: m_ins[31:0] = nv;
                12'hB82: m_ins[63:32] = nv;
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic tick();
        check_outs();
        adv();
    endtask

    task automatic idle();
        trapped = 0; mret = 0; wfi = 0; retired = 0;
        ecp = 0; ecause = 0; interupt = 0;
        csr_valid = 0; csr_addr = 12'h300; csr_op = 0; csr_wdata = 0;
    endtask

    task automatic csr_wr(input bit [11:0] a, input bit [1:0] op,
                          input bit [31:0] d);
        csr_valid = 1; csr_addr = a; csr_op = op; csr_wdata = d;
        tick();
        idle();
    endtask

    task automatic rd_chk(input string tag, input bit [11:0] a,
                          input bit [31:0] exp);
        csr_valid = 1; csr_addr = a; csr_op = 0;
        #1;
        chk(tag, csr_rdata, exp);
        tick();
        idle();
    endtask

    localparam int NADDR = 12;
    bit [11:0] addrs [NADDR] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                 12'h341, 12'h342, 12'h344, 12'hB00,
                                 12'hB80, 12'hB02, 12'hB82, 12'hF14};

    initial begin
        rstn = 0; mtip_in = 0; meip_in = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_outs();
        chk("rst_mstatus", csr_rdata, 32'h1800);
        @(negedge clk);
        rstn = 1;

        // Gated timer interrupt.
        csr_wr(12'h304, 2'b01, 32'h888);
        csr_wr(12'h300, 2'b10, 32'h8);
        mtip_in = 1;
        #1;
        chk("tp_tip", tip, 1);
        chk("tp_sip", sip, 0);
        chk("tp_eip", eip, 0);
        rd_chk("tp_mip", 12'h344, 32'h80);
        mtip_in = 0;

        // Synchronous exception trap.
        csr_wr(12'h305, 2'b01, 32'h200);
        trapped = 1; ecp = 32'h1000; ecause = 4'd2; interupt = 0;
        tick();
        idle();
        #1;
        chk("trap_rv", redirect_valid, 1);
        chk("trap_pc", redirect_pc, 32'h200);
        rd_chk("trap_mepc", 12'h341, 32'h1000);
        chk("trap_rv_pulse", redirect_valid, 0);
        rd_chk("trap_mcause", 12'h342, 32'h2);
        rd_chk("trap_mstatus", 12'h300, 32'h1880);

        // mret back to the trapping PC.
        mret = 1;
        tick();
        idle();
        #1;
        chk("mret_rv", redirect_valid, 1);
        chk("mret_pc", redirect_pc, 32'h1000);
        rd_chk("mret_mstatus", 12'h300, 32'h1888);

        // WFI with MIE clear wakes on external interrupt, no redirect.
        csr_wr(12'h300, 2'b11, 32'h8);
        wfi = 1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wfi_sleep", wfi_stall, 1);
            tick();
        end
        meip_in = 1;
        tick();
        #1;
        chk("wfi_wake", wfi_stall, 0);
        chk("wfi_norv", redirect_valid, 0);
        meip_in = 0;

        // Trap beats a same-cycle mepc write.
        csr_valid = 1; csr_addr = 12'h341; csr_op = 2'b01;
        csr_wdata = 32'hDEAD_BEE0;
        trapped = 1; ecp = 32'h2000; ecause = 4'd5;
        tick();
        idle();
        rd_chk("trap_vs_wr", 12'h341, 32'h2000);

        // minstret carry from lo to hi.
        csr_wr(12'hB82, 2'b01, 32'h0);
        csr_wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
        retired = 1;
        tick();
        idle();
        rd_chk("ins_lo", 12'hB02, 32'h0);
        rd_chk("ins_hi", 12'hB82, 32'h1);

`ifdef MTVEC_VECTORED_EN
        csr_wr(12'h305, 2'b01, 32'h201);
        trapped = 1; interupt = 1; ecause = 4'd7;
        tick();
        idle();
        #1;
        chk("vec_pc", redirect_pc, 32'h21C);
`else
        csr_wr(12'h305, 2'b01, 32'h203);
        rd_chk("mtvec_direct", 12'h305, 32'h200);
`endif
        rd_chk("hartid", 12'hF14, 32'h0);

        // Reset while sleeping.
        csr_wr(12'h304, 2'b01, 32'h0);
        wfi = 1;
        tick();
        idle();
        #1;
        chk("rst_sleep_in", wfi_stall, 1);
        rstn = 0;
        #1;
        chk("rst_sleep_out", wfi_stall, 0);
        model_reset();
        @(negedge clk);
        rstn = 1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            trapped   = ($urandom_range(15) == 0);
            mret      = ($urandom_range(15) == 0);
            wfi       = ($urandom_range(20) == 0);
            retired   = $urandom_range(1);
            ecp       = $urandom;
            ecause    = 4'($urandom);
            interupt  = $urandom_range(1);
            if ($urandom_range(7) == 0) mtip_in = $urandom_range(1);
            if ($urandom_range(7) == 0) meip_in = $urandom_range(1);
            csr_valid = $urandom_range(1);
            csr_addr  = ($urandom_range(9) == 0) ? 12'($urandom)
                      : addrs[$urandom_range(NADDR - 1)];
            csr_op    = 2'($urandom);
            csr_wdata = ($urandom_range(3) == 0) ? 32'h0000_0888 : $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
